// File: rtl/stim_player_pkg.sv
// Shared constants, opcode field layout and playback state encoding for the
// stimulus player.
package stim_player_pkg;

    localparam int DEPTH     = 64;
    localparam int OPW       = 6;
    localparam int AW        = 6;
    localparam int LENW      = 7;
    localparam int PLW       = 16;

    localparam int OBS_BIT   = 5;
    localparam int K_MSB     = 4;
    localparam int K_LSB     = 1;
    localparam int START_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    function automatic logic [PLW-1:0] sat_inc(input logic [PLW-1:0] v);
        return (v == {PLW{1'b1}}) ? v : v + PLW'(1);
    endfunction

endpackage

// File: rtl/stim_player_if.sv
// Load/control/observe bundle between the stimulus player and its driver.
interface stim_player_if;
    import stim_player_pkg::*;

    logic                   load_en;
    logic [AW-1:0]          load_addr;
    logic [OPW-1:0]         load_data;
    logic [LENW-1:0]        length;
    logic                   run;
    logic                   stop;
    logic                   hold;
    logic                   loop_en;

    logic                   obs;
    logic [K_MSB-K_LSB:0]   k;
    logic                   start;
    logic [AW-1:0]          pc;
    logic                   busy;
    logic                   done;
    logic [PLW-1:0]         played;

    modport master (
        output load_en, load_addr, load_data, length, run, stop, hold, loop_en,
        input  obs, k, start, pc, busy, done, played
    );

    modport slave (
        input  load_en, load_addr, load_data, length, run, stop, hold, loop_en,
        output obs, k, start, pc, busy, done, played
    );

endinterface

// File: rtl/stim_player_ram.sv
// Opcode store: one write port, registered read that holds its value while
// no read is requested.
module stim_ram #(
    parameter int DEPTH = 64,
    parameter int OPW   = 6,
    parameter int AW    = 6
) (
    input  logic           i_clk,
    input  logic           i_we,
    input  logic [AW-1:0]  i_waddr,
    input  logic [OPW-1:0] i_wdata,
    input  logic           i_re,
    input  logic [AW-1:0]  i_raddr,
    output logic [OPW-1:0] o_rdata
);

    logic [OPW-1:0] r_mem [DEPTH];
    logic [OPW-1:0] r_rdata_p1;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            r_rdata_p1 <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata_p1;

endmodule

// File: rtl/stim_player.sv
// Plays a loaded opcode list onto obs/k/start one entry per cycle, with
// pause, abort and wrap-around looping.
module stim_player #(
    parameter int DEPTH = stim_player_pkg::DEPTH,
    parameter int OPW   = stim_player_pkg::OPW
) (
    input  logic          clock,
    input  logic          reset,
    stim_player_if.slave  bus
);
    import stim_player_pkg::*;

    localparam logic [LENW-1:0] DEPTH_L = LENW'(DEPTH);

    state_t          r_state;
    state_t          w_next;
    logic [LENW-1:0] r_len;
    logic [AW-1:0]   r_pc;
    logic            r_vld_p1;
    logic [PLW-1:0]  r_played;
    logic            r_done;

    logic [OPW-1:0]  w_rdata_p1;
    logic [LENW-1:0] w_len_clamp;
    logic            w_active;
    logic            w_last;
    logic            w_start_run;
    logic            w_finish;
    logic            w_fetch;
    logic            w_we;
    logic [AW-1:0]   w_raddr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_run)
                    w_next = ST_PLAY;
            end
            ST_PLAY, ST_PAUSE: begin
                if (bus.stop)
                    w_next = ST_IDLE;
                else if (bus.hold)
                    w_next = ST_PAUSE;
                else if (w_finish)
                    w_next = ST_IDLE;
                else
                    w_next = ST_PLAY;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // The address fetched is the entry shown after the next edge; before the
    // first entry is visible it is always entry 0.
    always_comb begin
        w_active    = (r_state != ST_IDLE);
        w_last      = r_vld_p1 && (LENW'(r_pc) == r_len - LENW'(1));
        w_len_clamp = (bus.length > DEPTH_L) ? DEPTH_L : bus.length;
        w_start_run = 1'b0;
        w_finish    = 1'b0;
        w_fetch     = 1'b0;
        w_raddr     = '0;
        w_we        = bus.load_en && !w_active;
        if (!w_active) begin
            w_start_run = bus.run && (bus.length != '0);
        end else if (!bus.stop && !bus.hold) begin
            if (w_last && !bus.loop_en) begin
                w_finish = 1'b1;
            end else begin
                w_fetch = 1'b1;
                if (r_vld_p1 && !w_last)
                    w_raddr = r_pc + AW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_len    <= '0;
            r_pc     <= '0;
            r_vld_p1 <= 1'b0;
            r_played <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_start_run) begin
                r_len    <= w_len_clamp;
                r_played <= '0;
                r_pc     <= '0;
            end
            if (w_fetch) begin
                r_pc     <= w_raddr;
                r_vld_p1 <= 1'b1;
                r_played <= sat_inc(r_played);
            end else if (w_finish || (w_active && bus.stop)) begin
                r_pc     <= '0;
                r_vld_p1 <= 1'b0;
            end
        end
    end

    stim_ram #(
        .DEPTH (DEPTH),
        .OPW   (OPW),
        .AW    (AW)
    ) u_ram (
        .i_clk   (clock),
        .i_we    (w_we),
        .i_waddr (bus.load_addr),
        .i_wdata (bus.load_data),
        .i_re    (w_fetch),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata_p1)
    );

    assign bus.obs    = r_vld_p1 & w_rdata_p1[OBS_BIT];
    assign bus.k      = r_vld_p1 ? w_rdata_p1[K_MSB:K_LSB] : '0;
    assign bus.start  = r_vld_p1 & w_rdata_p1[START_BIT];
    assign bus.pc     = r_pc;
    assign bus.busy   = w_active;
    assign bus.done   = r_done;
    assign bus.played = r_played;

endmodule

// File: tb/tb_stim_player.sv
// Bench for stim_player: directed vector table, corner sequences and a random
// run compared against a list-position model of playback.
module tb_stim_player;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stim_player_if bus();

    stim_player dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    int errs   = 0;
    int checks = 0;

    // Model: memory image plus the index of the entry on screen (-1 = none).
    logic [5:0] m_mem [64];
    int         m_idx    = -1;
    int         m_len    = 0;
    int         m_played = 0;
    bit         m_busy   = 1'b0;
    bit         m_done   = 1'b0;

    typedef struct {
        bit         run;
        bit         lp;
        logic [6:0] len;
        logic [5:0] out;
        logic [5:0] pc;
        bit         cpc;
        bit         busy;
        bit         done;
        logic [15:0] played;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [5:0] m_out();
        return (m_idx >= 0) ? m_mem[m_idx] : 6'd0;
    endfunction

    function automatic logic [5:0] dut_word();
        return {bus.obs, bus.k, bus.start};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        if (!m_busy) begin
            if (bus.load_en)
                m_mem[bus.load_addr] = bus.load_data;
            if (bus.run && bus.length != 7'd0) begin
                m_busy   = 1'b1;
                m_len    = (bus.length > 7'd64) ? 64 : int'(bus.length);
                m_played = 0;
                m_idx    = -1;
            end
        end else if (bus.stop) begin
            m_busy = 1'b0;
            m_idx  = -1;
        end else if (!bus.hold) begin
            if (m_idx == m_len - 1 && !bus.loop_en) begin
                m_busy = 1'b0;
                m_idx  = -1;
                m_done = 1'b1;
            end else begin
                m_idx = (m_idx + 1) % m_len;
                if (m_played < 65535)
                    m_played++;
            end
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_idx    = -1;
        m_played = 0;
        m_done   = 1'b0;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("out", 32'(dut_word()), 32'(m_out()));
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("played", 32'(bus.played), 32'(m_played));
        if (m_idx >= 0)
            chk("pc", 32'(bus.pc), 32'(m_idx));
    endtask

    task automatic drive(input bit run, input bit hold, input bit stop, input bit lp,
                         input logic [6:0] len);
        bus.load_en = 1'b0;
        bus.run     = run;
        bus.hold    = hold;
        bus.stop    = stop;
        bus.loop_en = lp;
        bus.length  = len;
    endtask

    task automatic load(input int a, input logic [5:0] d);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        bus.load_en   = 1'b1;
        bus.load_addr = 6'(a);
        bus.load_data = d;
        cyc();
        bus.load_en = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_out"}, 32'(dut_word()), 32'd0);
        chk({nm, "_pc"}, 32'(bus.pc), 32'd0);
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_done"}, 32'(bus.done), 32'd0);
        chk({nm, "_played"}, 32'(bus.played), 32'd0);
    endtask

    logic [5:0] ent [5];
    int         pc_exp [7];
    int         cnt2;
    int         busy_cycles;
    bit         done_seen;
    logic [5:0] r;

    initial begin
        ent = '{6'h21, 6'h12, 6'h2C, 6'h07, 6'h38};
        pc_exp = '{0, 1, 2, 0, 1, 2, 0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        bus.load_addr = '0;
        bus.load_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: length=0 ignored, then the three-entry playback.
        load(0, 6'b100011);
        load(1, 6'b000101);
        load(2, 6'b111110);
        tbl[0] = '{1'b1, 1'b0, 7'd0, 6'h00, 6'd0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1] = '{1'b0, 1'b0, 7'd0, 6'h00, 6'd0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 1'b0, 7'd3, 6'h00, 6'd0, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[3] = '{1'b0, 1'b0, 7'd3, 6'h23, 6'd0, 1'b1, 1'b1, 1'b0, 16'd1};
        tbl[4] = '{1'b0, 1'b0, 7'd3, 6'h05, 6'd1, 1'b1, 1'b1, 1'b0, 16'd2};
        tbl[5] = '{1'b0, 1'b0, 7'd3, 6'h3E, 6'd2, 1'b1, 1'b1, 1'b0, 16'd3};
        tbl[6] = '{1'b0, 1'b0, 7'd3, 6'h00, 6'd0, 1'b0, 1'b0, 1'b1, 16'd3};
        tbl[7] = '{1'b0, 1'b0, 7'd3, 6'h00, 6'd0, 1'b0, 1'b0, 1'b0, 16'd3};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].run, 1'b0, 1'b0, tbl[i].lp, tbl[i].len);
            cyc();
            chk("tbl_out", 32'(dut_word()), 32'(tbl[i].out));
            chk("tbl_busy", 32'(bus.busy), 32'(tbl[i].busy));
            chk("tbl_done", 32'(bus.done), 32'(tbl[i].done));
            chk("tbl_played", 32'(bus.played), 32'(tbl[i].played));
            if (tbl[i].cpc)
                chk("tbl_pc", 32'(bus.pc), 32'(tbl[i].pc));
        end

        // Looping: 0,1,2,0,1,2,0 with no gap and no done.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 7'd3);
        cyc();
        done_seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 7'd3);
            cyc();
            chk("loop_pc", 32'(bus.pc), 32'(pc_exp[i]));
            chk("loop_busy", 32'(bus.busy), 32'd1);
            if (bus.done) done_seen = 1'b1;
        end
        chk("loop_no_done", 32'(done_seen), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 7'd3);
        cyc();

        // Hold three cycles while entry 2 is shown.
        for (int i = 0; i < 5; i++) load(i, ent[i]);
        cnt2 = 0;
        for (int i = 0; i < 10; i++) begin
            drive(i == 0, i >= 4 && i <= 6, 1'b0, 1'b0, 7'd5);
            cyc();
            if (bus.busy && dut_word() == ent[2]) cnt2++;
        end
        chk("hold_entry2_cycles", 32'(cnt2), 32'd4);
        chk("hold_played", 32'(bus.played), 32'd5);

        // Stop during entry 1.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd5);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd5);
        cyc();
        cyc();
        chk("stop_pre_entry1", 32'(dut_word()), 32'(ent[1]));
        drive(1'b0, 1'b1, 1'b1, 1'b0, 7'd5);
        cyc();
        chk("stop_out", 32'(dut_word()), 32'd0);
        chk("stop_busy", 32'(bus.busy), 32'd0);
        chk("stop_done", 32'(bus.done), 32'd0);

        // Asynchronous reset mid-playback, then rerun from intact memory.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd5);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd5);
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd5);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd5);
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i < 5) chk("rerun_entry", 32'(dut_word()), 32'(ent[i]));
        end

        // Writes during playback must not land.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd5);
        cyc();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd5);
            bus.load_en   = (i < 3);
            bus.load_addr = 6'd1;
            bus.load_data = 6'h3F;
            cyc();
        end
        bus.load_en = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd5);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd5);
        cyc();
        cyc();
        chk("readback_entry1", 32'(dut_word()), 32'(ent[1]));
        for (int i = 0; i < 4; i++) cyc();

        // Fill memory, then length above DEPTH plays DEPTH entries.
        for (int i = 0; i < 64; i++) begin
            r = 6'($urandom_range(1, 63));
            load(i, r);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd100);
        cyc();
        busy_cycles = bus.busy ? 1 : 0;
        done_seen = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd100);
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (!bus.busy) begin
                done_seen = bus.done;
                break;
            end
            busy_cycles++;
        end
        chk("len100_busy_cycles", 32'(busy_cycles), 32'd65);
        chk("len100_played", 32'(bus.played), 32'd64);
        chk("len100_done", 32'(done_seen), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: bus.length = 7'($urandom_range(0, 2));
                1: bus.length = 7'($urandom_range(60, 127));
                default: bus.length = 7'($urandom_range(1, 8));
            endcase
            bus.run       = ($urandom_range(0, 9) == 0);
            bus.hold      = ($urandom_range(0, 6) == 0);
            bus.stop      = ($urandom_range(0, 40) == 0);
            bus.loop_en   = ($urandom_range(0, 3) == 0);
            bus.load_en   = ($urandom_range(0, 2) == 0);
            bus.load_addr = 6'($urandom_range(0, 63));
            bus.load_data = 6'($urandom_range(0, 63));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
